// File: rtl/mcse_gpio_pkt_responder.sv
// mcse_gpio_pkt_responder
// Target-side endpoint for the boot controller's GPIO register packet stream.
// Incoming packets are buffered in a small FIFO and decoded into reads/writes
// on a local register bank. Every read returns a response packet.
// Optional build macro: MCSE_PKT_LOCK_EN makes bit 0 of register 0 a
// write-once lock that blocks all later register writes until reset.
module mcse_gpio_pkt_responder #(
    parameter int gpio_AW    = 32,
    parameter int gpio_PW    = 2*gpio_AW+40,
    parameter int NREGS      = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       access_in,
    input  logic [gpio_PW-1:0]         packet_in,
    output logic                       wait_out,
    output logic                       access_out,
    output logic [gpio_PW-1:0]         packet_out,
    input  logic                       wait_in,
    output logic [NREGS*gpio_AW-1:0]   reg_q,
    output logic                       err_sticky,
    output logic [7:0]                 err_count
);

    localparam int IDX_W = $clog2(NREGS);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int SRC_W = gpio_PW - 2*gpio_AW - 8;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state, state_next;

    logic [gpio_PW-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   fifo_count, count_next;
    logic               push, pop, fifo_empty;

    logic [gpio_PW-1:0] hold_pkt;
    logic [gpio_PW-1:0] resp_pkt;
    logic [gpio_AW-1:0] regs [NREGS];

    logic               hold_write;
    logic [4:0]         hold_ctrl;
    logic [gpio_AW-1:0] hold_dst;
    logic [gpio_AW-1:0] hold_data;
    logic [SRC_W-1:0]   hold_src;
    logic [IDX_W-1:0]   hold_idx;
    logic               in_range;
    logic               locked;
    logic [gpio_AW-1:0] rd_val;
    logic               exec_active, resp_load, reg_write, err_inc, err_set;
    logic               unused_datamode;

    // Request field decode from the holding register; datamode is ignored.
    assign hold_write      = hold_pkt[0];
    assign hold_ctrl       = hold_pkt[7:3];
    assign hold_dst        = hold_pkt[gpio_AW+7:8];
    assign hold_data       = hold_pkt[2*gpio_AW+7:gpio_AW+8];
    assign hold_src        = hold_pkt[gpio_PW-1:2*gpio_AW+8];
    assign hold_idx        = hold_dst[IDX_W+1:2];
    assign in_range        = (hold_dst[gpio_AW-1:IDX_W+2] == '0);
    assign rd_val          = in_range ? regs[hold_idx] : '0;
    assign unused_datamode = ^hold_pkt[2:1];

`ifdef MCSE_PKT_LOCK_EN
    assign locked = regs[0][0];
`else
    assign locked = 1'b0;
`endif

    // Input acceptance is refused while the registered full flag is up.
    assign push       = access_in && !wait_out;
    assign fifo_empty = (fifo_count == '0);
    assign count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);

    assign reg_write = exec_active && hold_write && in_range && !locked;
    assign err_inc   = exec_active && (!in_range || (hold_write && locked));
    assign err_set   = exec_active && !in_range;

    // FIFO storage, no reset needed since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= packet_in;
        end
    end

    // FIFO pointers, occupancy and the registered full flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            wait_out   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= count_next;
            wait_out   <= (count_next == CNT_W'(FIFO_DEPTH));
        end
    end

    // Holding register for the packet being executed and the response buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_pkt <= '0;
            resp_pkt <= '0;
        end else begin
            if (pop) hold_pkt <= fifo_mem[rd_ptr];
            if (resp_load) begin
                resp_pkt <= {SRC_W'(hold_dst), rd_val, gpio_AW'(hold_src),
                             hold_ctrl, 2'b10, 1'b1};
            end
        end
    end

    // Register bank updates from in-range, unlocked writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (reg_write) begin
            regs[hold_idx] <= hold_data;
        end
    end

    // Error reporting: sticky flag for range errors, saturating counter for all rejects.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_sticky <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            if (err_set) err_sticky <= 1'b1;
            if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // FSM next-state: writes return straight to IDLE, every read responds.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (!fifo_empty) state_next = EXEC;
            EXEC: state_next = hold_write ? IDLE : RESP;
            RESP: if (!wait_in) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: pop in IDLE, execute in EXEC, present the response in RESP.
    always_comb begin
        pop         = (state == IDLE) && !fifo_empty;
        exec_active = (state == EXEC);
        resp_load   = (state == EXEC) && !hold_write;
        access_out  = (state == RESP);
    end

    assign packet_out = resp_pkt;

    // Flattened view of the register bank.
    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NREGS; i++) reg_q[i*gpio_AW +: gpio_AW] = regs[i];
    end

endmodule

// File: tb/tb_mcse_gpio_pkt_responder.sv
// Testbench for mcse_gpio_pkt_responder: random and directed packets checked
// against a transaction-level model of the register bank and error counters.
module tb_mcse_gpio_pkt_responder;

    localparam int AW = 32;
    localparam int PW = 2*AW+40;
    localparam int NR = 8;
`ifdef MCSE_PKT_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              access_in;
    logic [PW-1:0]     packet_in;
    logic              wait_out;
    logic              access_out;
    logic [PW-1:0]     packet_out;
    logic              wait_in;
    logic [NR*AW-1:0]  reg_q;
    logic              err_sticky;
    logic [7:0]        err_count;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] m_regs [NR];
    int            m_cnt;
    bit            m_sticky;
    logic [PW-1:0] exp_q [$];
    logic [PW-1:0] got_q [$];
    bit            saw_wait;
    bit            rand_stall;

    mcse_gpio_pkt_responder #(.gpio_AW(AW), .gpio_PW(PW), .NREGS(NR), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .access_in(access_in), .packet_in(packet_in),
        .wait_out(wait_out), .access_out(access_out), .packet_out(packet_out),
        .wait_in(wait_in), .reg_q(reg_q), .err_sticky(err_sticky), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Collect every completed response handshake.
    always @(negedge clk) begin
        if (rst === 1'b1 && access_out === 1'b1 && wait_in === 1'b0) got_q.push_back(packet_out);
    end

    // Optional random downstream stall.
    always @(posedge clk) begin
        if (rand_stall) begin
            #1 wait_in = 1'($urandom_range(0, 1));
        end
    end

    function automatic logic [PW-1:0] mk_pkt(input bit wr, input logic [4:0] ctrl,
                                             input logic [31:0] dst, input logic [31:0] data,
                                             input logic [31:0] src);
        logic [1:0] dm;
        dm = 2'($urandom);
        return {src, data, dst, ctrl, dm, wr};
    endfunction

    function automatic logic [PW-1:0] mk_resp(input logic [PW-1:0] req, input logic [31:0] data);
        return {req[39:8], data, req[103:72], req[7:3], 2'b10, 1'b1};
    endfunction

    function automatic logic [NR*AW-1:0] model_regq();
        logic [NR*AW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*AW +: AW] = m_regs[i];
        return v;
    endfunction

    // Apply one accepted request to the model, in acceptance order.
    function automatic void model_accept(input logic [PW-1:0] p);
        bit            wr;
        logic [31:0]   dst, data;
        int unsigned   word;
        wr   = p[0];
        dst  = p[39:8];
        data = p[71:40];
        word = dst / 4;
        if (word >= NR) begin
            m_sticky = 1'b1;
            if (m_cnt < 255) m_cnt++;
            if (!wr) exp_q.push_back(mk_resp(p, 32'd0));
        end else if (wr) begin
            if (LOCK_EN && m_regs[0][0]) begin
                if (m_cnt < 255) m_cnt++;
            end else begin
                m_regs[word] = data;
            end
        end else begin
            exp_q.push_back(mk_resp(p, m_regs[word]));
        end
    endfunction

    task automatic send(input logic [PW-1:0] p);
        int tries;
        tries = 0;
        @(posedge clk); #1;
        access_in = 1'b1;
        packet_in = p;
        @(negedge clk);
        while (wait_out === 1'b1 && tries < 200) begin
            saw_wait = 1'b1;
            @(negedge clk);
            tries++;
        end
        if (tries >= 200) begin
            checks++; errors++;
            $display("[TB] FAIL send_timeout: wait_out stuck at %b, required 0", wait_out);
        end else begin
            model_accept(p);
        end
    endtask

    task automatic drop_access();
        @(posedge clk); #1;
        access_in = 1'b0;
    endtask

    task automatic drain();
        rand_stall = 1'b0;
        drop_access();
        wait_in = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        access_in = 1'b0;
        wait_in = 1'b0;
        rand_stall = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_cnt = 0; m_sticky = 1'b0;
        exp_q.delete(); got_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; access_in = 1'b0; wait_in = 1'b0; packet_in = '0; rand_stall = 1'b0;
        #3;
        checks++;
        if ({wait_out, access_out, err_sticky} !== 3'b000 || packet_out !== '0 ||
            reg_q !== '0 || err_count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: wait=%b acc=%b stk=%b cnt=%0d pkt=%h, required all zero",
                     wait_out, access_out, err_sticky, err_count, packet_out);
        end
        apply_reset();
        @(negedge clk);
        checks++;
        if (access_out !== 1'b0 || wait_out !== 1'b0 || reg_q !== '0) begin
            errors++;
            $display("[TB] FAIL after_reset: acc=%b wait=%b, required 0 0", access_out, wait_out);
        end
    endtask

    task automatic test_write_read();
        logic [PW-1:0] rd;
        apply_reset();
        send(mk_pkt(1'b1, 5'h0A, 32'h8, 32'hCAFE_F00D, 32'h1234));
        drop_access();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (c < 2 && reg_q[95:64] !== 32'h0) begin
                errors++;
                $display("[TB] FAIL wr_latency_early c=%0d: reg2=%h, required 0", c, reg_q[95:64]);
            end else if (c == 2 && reg_q[95:64] !== 32'hCAFE_F00D) begin
                errors++;
                $display("[TB] FAIL wr_latency: reg2=%h, required cafef00d", reg_q[95:64]);
            end
        end
        rd = mk_pkt(1'b0, 5'h13, 32'h8, 32'h0, 32'h1234);
        send(rd);
        drop_access();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (access_out !== (c == 2)) begin
                errors++;
                $display("[TB] FAIL rd_latency c=%0d: access_out=%b, required %b", c, access_out, c == 2);
            end
        end
        checks++;
        if (packet_out[39:8] !== 32'h1234 || packet_out[71:40] !== 32'hCAFE_F00D ||
            packet_out[0] !== 1'b1 || packet_out[2:1] !== 2'b10 || packet_out[7:3] !== 5'h13 ||
            packet_out[103:72] !== 32'h8) begin
            errors++;
            $display("[TB] FAIL rd_fields: got %h, required dst=1234 data=cafef00d src=8", packet_out);
        end
        drain();
        checks++;
        if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            errors++;
            $display("[TB] FAIL rd_resp_count: got %0d responses, required 1 matching", got_q.size());
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0] g, e;
        apply_reset();
        saw_wait = 1'b0;
        send(mk_pkt(1'b1, 5'h1, 32'h14, 32'h1111_AAAA, 32'h1));
        send(mk_pkt(1'b1, 5'h2, 32'h18, 32'h2222_BBBB, 32'h2));
        send(mk_pkt(1'b1, 5'h3, 32'h15, 32'h3333_CCCC, 32'h3));
        send(mk_pkt(1'b1, 5'h4, 32'h1C, 32'h4444_DDDD, 32'h4));
        for (int i = 4; i < 8; i++) send(mk_pkt(1'b0, 5'(i), 32'(i*4), 32'h0, 32'(i)));
        drain();
        checks++;
        if (saw_wait !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_wait_out: wait_out seen=%b, required 1", saw_wait);
        end
        checks++;
        if (reg_q !== model_regq() || reg_q[191:160] !== 32'h3333_CCCC) begin
            errors++;
            $display("[TB] FAIL b2b_regs: reg_q=%h, required %h", reg_q, model_regq());
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL b2b_resp_count: got %0d, required %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("[TB] FAIL b2b_resp: got %h, required %h", g, e);
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_resp_stall();
        logic [PW-1:0] held;
        int tries;
        apply_reset();
        send(mk_pkt(1'b1, 5'h0, 32'h10, 32'h5A5A_0001, 32'h77));
        drop_access();
        wait_in = 1'b1;
        send(mk_pkt(1'b0, 5'h1F, 32'h10, 32'h0, 32'hBEEF));
        drop_access();
        tries = 0;
        @(negedge clk);
        while (access_out !== 1'b1 && tries < 20) begin @(negedge clk); tries++; end
        held = packet_out;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (access_out !== 1'b1 || packet_out !== held) begin
                errors++;
                $display("[TB] FAIL stall_hold c=%0d: acc=%b pkt=%h, required 1 %h", c, access_out, packet_out, held);
            end
            @(negedge clk);
        end
        @(posedge clk); #1 wait_in = 1'b0;
        @(negedge clk);
        checks++;
        if (access_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_release: access_out=%b, required 1", access_out);
        end
        @(negedge clk);
        checks++;
        if (access_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stall_leave: access_out=%b, required 0", access_out);
        end
        drain();
        checks++;
        if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0] || held !== exp_q[0]) begin
            errors++;
            $display("[TB] FAIL stall_resp: got %0d responses, first %h", got_q.size(), held);
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_out_of_range();
        apply_reset();
        send(mk_pkt(1'b1, 5'h2, 32'h40, $urandom, 32'h9));
        drain();
        checks++;
        if (reg_q !== '0 || err_sticky !== 1'b1 || err_count !== 8'd1) begin
            errors++;
            $display("[TB] FAIL oor_write: stk=%b cnt=%0d, required 1 1 and no register change", err_sticky, err_count);
        end
        send(mk_pkt(1'b0, 5'h2, 32'h40, 32'h0, 32'h9));
        drain();
        checks++;
        if (got_q.size() != 1 || got_q[0][71:40] !== 32'h0 || got_q[0] !== exp_q[0]) begin
            errors++;
            $display("[TB] FAIL oor_read: got %0d responses, required 1 with data 0", got_q.size());
        end
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 298; i++) send(mk_pkt(1'($urandom), 5'($urandom), $urandom | 32'h20, $urandom, $urandom));
        drain();
        checks++;
        if (err_count !== 8'd255 || m_cnt != 255 || err_sticky !== 1'b1 || reg_q !== '0) begin
            errors++;
            $display("[TB] FAIL oor_saturate: cnt=%0d stk=%b, required 255 1", err_count, err_sticky);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL oor_resp_count: got %0d, required %0d", got_q.size(), exp_q.size());
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_random();
        logic [PW-1:0] g, e;
        int unsigned word;
        apply_reset();
        rand_stall = 1'b1;
        for (int i = 0; i < 80; i++) begin
            word = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(8, 40)) : 32'($urandom_range(0, NR-1));
            send(mk_pkt(1'($urandom), 5'($urandom), word*4 + $urandom_range(0, 3), $urandom, $urandom));
            if ($urandom_range(0, 3) == 0) drop_access();
        end
        drain();
        checks++;
        if (reg_q !== model_regq()) begin
            errors++;
            $display("[TB] FAIL rand_regs: reg_q=%h, required %h", reg_q, model_regq());
        end
        checks++;
        if (err_count !== 8'(m_cnt) || err_sticky !== m_sticky) begin
            errors++;
            $display("[TB] FAIL rand_err: cnt=%0d stk=%b, required %0d %b", err_count, err_sticky, m_cnt, m_sticky);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("[TB] FAIL rand_resp_count: got %0d, required %0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("[TB] FAIL rand_resp: got %h, required %h", g, e);
            end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_lock();
        logic [31:0] want3;
        logic [7:0]  want_cnt;
        want3    = LOCK_EN ? 32'h0 : 32'hAA;
        want_cnt = LOCK_EN ? 8'd1 : 8'd0;
        apply_reset();
        send(mk_pkt(1'b1, 5'h0, 32'h0, 32'h1, 32'h5));
        send(mk_pkt(1'b1, 5'h0, 32'hC, 32'hAA, 32'h5));
        send(mk_pkt(1'b0, 5'h6, 32'hC, 32'h0, 32'h5));
        drain();
        checks++;
        if (reg_q[127:96] !== want3 || reg_q[31:0] !== 32'h1 || reg_q !== model_regq()) begin
            errors++;
            $display("[TB] FAIL lock_regs: reg3=%h reg0=%h, required %h 1", reg_q[127:96], reg_q[31:0], want3);
        end
        checks++;
        if (err_count !== want_cnt || err_sticky !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lock_err: cnt=%0d stk=%b, required %0d 0", err_count, err_sticky, want_cnt);
        end
        checks++;
        if (got_q.size() != 1 || got_q[0][71:40] !== want3) begin
            errors++;
            $display("[TB] FAIL lock_read: got %0d responses, required 1 with data %h", got_q.size(), want3);
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset_mid();
        int tries;
        apply_reset();
        send(mk_pkt(1'b1, 5'h0, 32'h8, 32'h1234_5678, 32'h1));
        send(mk_pkt(1'b1, 5'h0, 32'h50, 32'h0, 32'h1));
        drop_access();
        wait_in = 1'b1;
        send(mk_pkt(1'b0, 5'h3, 32'h8, 32'h0, 32'h2));
        drop_access();
        tries = 0;
        @(negedge clk);
        while (access_out !== 1'b1 && tries < 20) begin @(negedge clk); tries++; end
        send(mk_pkt(1'b1, 5'h0, 32'h4, 32'h1, 32'h3));
        send(mk_pkt(1'b1, 5'h0, 32'h4, 32'h2, 32'h3));
        drop_access();
        @(negedge clk);
        checks++;
        if (wait_out !== 1'b1 || access_out !== 1'b1 || reg_q === '0 || err_count === 8'd0) begin
            errors++;
            $display("[TB] FAIL mid_setup: wait=%b acc=%b cnt=%0d, required full FIFO in RESP", wait_out, access_out, err_count);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (access_out !== 1'b0 || wait_out !== 1'b0 || reg_q !== '0 || err_count !== 8'd0 ||
            err_sticky !== 1'b0 || packet_out !== '0) begin
            errors++;
            $display("[TB] FAIL mid_reset: acc=%b wait=%b cnt=%0d, required all cleared", access_out, wait_out, err_count);
        end
        apply_reset();
        drain();
        checks++;
        if (access_out !== 1'b0 || reg_q !== '0 || got_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL mid_after: acc=%b responses=%0d, required idle and none", access_out, got_q.size());
        end
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        saw_wait = 1'b0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_resp_stall();
        test_out_of_range();
        test_lock();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
